univ_shreg_n: RTL and testbench
===============================

# univ_shreg_n

Parametrised universal shift register, next generation of the 4-bit 74HC194-style register. It generalises the width and adds rotate, arithmetic-shift and clear modes. It also adds a burst sequencer that performs exactly WIDTH shifts from a single START pulse. It sits in the same logic-function library as the NAND/mux/shift-register parts and is used standalone or as a serial/parallel converter.

## Interface
- WIDTH, 4, register width in bits (≥1); bit 0 is the shift-right entry end, bit WIDTH-1 the shift-left entry end.
- CP  input  1  clock, rising-edge.
- MR  input  1  reset, synchronous, active-low.
- S  input  3  mode select (see Operation).
- DSR  input  1  serial data in for shift right (enters Q[0]).
- DSL  input  1  serial data in for shift left (enters Q[WIDTH-1]).
- D  input  [0:WIDTH-1]  parallel load data.
- START  input  1  burst request; sampled only in IDLE.
- Q  output  [0:WIDTH-1]  register contents.
- QSR  output  1  serial out, right end: equals Q[WIDTH-1].
- QSL  output  1  serial out, left end: equals Q[0].
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse after the final burst shift.

## Operation
- Priority at each CP edge: MR=0, then burst RUN, then S.
- MR=0 sets Q=0, BUSY=0, DONE=0, FSM=IDLE and count=0.
- Modes, applied at each edge while IDLE:
  - 000: hold.
  - 001: shift right; Q[0]<=DSR, Q[i]<=Q[i-1].
  - 010: shift left; Q[WIDTH-1]<=DSL, Q[i]<=Q[i+1].
  - 011: parallel load; Q<=D.
  - 100: rotate right; Q[0]<=Q[WIDTH-1].
  - 101: rotate left; Q[WIDTH-1]<=Q[0].
  - 110: arithmetic shift right; Q[0] is kept and propagated.
  - 111: clear; Q<=0.
- Burst FSM has two states, IDLE and RUN.
  - Valid burst modes: 001, 010, 100, 101, 110.
  - In IDLE, if START=1 and S is a valid burst mode, the same edge performs shift 1 in that mode and latches the mode. Count is loaded to WIDTH-1.
  - If count>0 after that load, the FSM moves to RUN and BUSY=1.
  - START with any other mode is ignored, and the mode executes normally.
  - In RUN, every edge performs one shift in the latched mode and decrements count.
  - The edge performing shift WIDTH returns the FSM to IDLE, sets BUSY=0 and sets DONE=1.
  - In RUN, S and START are ignored. DSR/DSL are still sampled on every shift.
  - WIDTH=1: the START edge performs the single shift and sets DONE=1; BUSY stays 0.
- DONE clears on the next edge unless another single-shift burst (WIDTH=1) re-asserts it.
- A new START on the edge where DONE is high is accepted, because the FSM is IDLE.

## Timing
- Every mode has 1-cycle latency: Q reflects the mode at the edge where it is sampled.
- QSR and QSL are combinational from Q, with no extra latency.
- A burst occupies edges k to k+WIDTH-1, where k is the START edge.
- BUSY is high for the WIDTH-1 cycles after edge k.
- DONE is high for the one cycle after edge k+WIDTH-1.
- MR=0 mid-burst aborts at that edge: Q=0, BUSY=0, and DONE does not pulse.
- MR=0 on the same edge as START: reset wins and START is dropped.
- All outputs are registered except QSR and QSL.
- No asynchronous paths.

## Configuration
- UNIV_SHREG_BURST_EN defined: burst FSM, count, BUSY and DONE are present as described.
- Not defined:
  - No FSM or counter.
  - START is ignored.
  - BUSY and DONE are tied to 0.
  - The register behaves purely per S each cycle.
- The ports exist in both builds.

## Test plan
- Reset: WIDTH=4, S=011, D=1111, MR=0 for one edge -> Q=0000, BUSY=0, DONE=0. Then MR=1 for one edge -> Q=1111.
- Load/hold/shift:
  - Load 1010, then S=000 for 3 edges -> Q=1010 throughout.
  - From 1010, S=001, DSR=1 -> 1101, then 1110.
  - From 1010, S=010, DSL=0 -> 0100.
- Rotate/ASR/clear:
  - From 1000, S=100 -> 0100, 0010, 0001, 1000.
  - From 1000, S=110 -> 1100.
  - S=111 -> 0000.
- Burst:
  - Setup: Q=1011, S=101, START pulse.
  - Q sequence -> 0111, 1110, 1101, 1011.
  - BUSY high for 3 cycles; DONE high for 1 cycle after the 4th edge.
  - S=011 applied mid-burst is ignored.
- Abort:
  - Setup: burst with S=001, DSR=1, from 0000.
  - After 2 shifts (Q=1100), MR=0 -> Q=0000, BUSY=0, and DONE never pulses.
- Ignored START:
  - START=1 with S=011, D=0110 -> Q=0110, BUSY=0, DONE=0.
  - Build without UNIV_SHREG_BURST_EN: burst stimulus gives only a single shift per edge following S, and BUSY=DONE=0 throughout.

Source files
------------

// File: rtl/univ_shreg_n.sv
// univ_shreg_n - parametrised universal shift register with optional burst sequencer.
//
// Successor of the 4-bit 74HC194-style register: any WIDTH, plus rotate,
// arithmetic-shift-right and clear modes. With the burst sequencer built in,
// a single START pulse in a shift/rotate mode runs exactly WIDTH shifts.
//
// Configuration macro: UNIV_SHREG_BURST_EN
//   defined     : burst FSM, shift counter, BUSY and DONE are present.
//   not defined : register follows S every cycle, START is ignored,
//                 BUSY and DONE are tied low. Ports are identical in both builds.
//
// Ports:
//   CP     in   clock, rising edge
//   MR     in   synchronous active-low reset
//   S      in   [2:0] mode select
//                 000 hold, 001 shift right, 010 shift left, 011 load,
//                 100 rotate right, 101 rotate left, 110 arith shift right, 111 clear
//   DSR    in   serial input entering Q[0] on shift right
//   DSL    in   serial input entering Q[WIDTH-1] on shift left
//   D      in   [0:WIDTH-1] parallel load data
//   START  in   burst request, sampled only while idle
//   Q      out  [0:WIDTH-1] register contents
//   QSR    out  Q[WIDTH-1] (combinational)
//   QSL    out  Q[0] (combinational)
//   BUSY   out  burst in progress
//   DONE   out  one-cycle pulse after the final burst shift

module univ_shreg_n #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             MR,
    input  logic [2:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [0:WIDTH-1] D,
    input  logic             START,
    output logic [0:WIDTH-1] Q,
    output logic             QSR,
    output logic             QSL,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Next register value for one edge in the given mode.
    // Q is declared [0:WIDTH-1], so index 0 is the MSB of the vector:
    // '>>' moves Q[i-1] into Q[i] (shift right), '<<' moves Q[i+1] into Q[i].
    // Working on whole-vector shifts keeps WIDTH=1 legal with no special case.
    function automatic logic [0:WIDTH-1] next_value(
        input logic [2:0]       mode,
        input logic [0:WIDTH-1] cur,
        input logic             dsr,
        input logic             dsl,
        input logic [0:WIDTH-1] d
    );
        logic [0:WIDTH-1] nxt;
        nxt = cur;
        case (mode)
            MODE_HOLD: nxt = cur;
            MODE_SHR: begin
                nxt    = cur >> 1;
                nxt[0] = dsr;
            end
            MODE_SHL: begin
                nxt          = cur << 1;
                nxt[WIDTH-1] = dsl;
            end
            MODE_LOAD: nxt = d;
            MODE_ROR: begin
                nxt    = cur >> 1;
                nxt[0] = cur[WIDTH-1];
            end
            MODE_ROL: begin
                nxt          = cur << 1;
                nxt[WIDTH-1] = cur[0];
            end
            MODE_ASR: begin
                nxt    = cur >> 1;
                nxt[0] = cur[0];
            end
            MODE_CLR: nxt = '0;
            default:  nxt = cur;
        endcase
        return nxt;
    endfunction

    assign QSR = Q[WIDTH-1];
    assign QSL = Q[0];

`ifdef UNIV_SHREG_BURST_EN

    // Counter holds the shifts still to run after the current one, so it
    // needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [2:0]     burst_mode;

    // Only the pure shift/rotate modes may be bursted.
    function automatic logic is_burst_mode(input logic [2:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
               (mode == MODE_ROL) || (mode == MODE_ASR);
    endfunction

    // The START edge performs shift 1 itself; RUN covers shifts 2..WIDTH.
    // DONE is a registered pulse and drops on every edge that does not end
    // a burst.
    always_ff @(posedge CP) begin
        if (!MR) begin
            Q          <= '0;
            state      <= IDLE;
            count      <= '0;
            burst_mode <= MODE_HOLD;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else if (state == RUN) begin
            Q <= next_value(burst_mode, Q, DSR, DSL, D);
            if (count == CW'(1)) begin
                state <= IDLE;
                count <= '0;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
            end else begin
                count <= count - CW'(1);
                DONE  <= 1'b0;
            end
        end else begin
            Q    <= next_value(S, Q, DSR, DSL, D);
            DONE <= 1'b0;
            if (START && is_burst_mode(S)) begin
                burst_mode <= S;
                count      <= CW'(WIDTH - 1);
                if (WIDTH > 1) begin
                    state <= RUN;
                    BUSY  <= 1'b1;
                end else begin
                    DONE <= 1'b1;
                end
            end
        end
    end

`else

    logic unused_start;
    assign unused_start = START;

    assign BUSY = 1'b0;
    assign DONE = 1'b0;

    always_ff @(posedge CP) begin
        if (!MR) begin
            Q <= '0;
        end else begin
            Q <= next_value(S, Q, DSR, DSL, D);
        end
    end

`endif

endmodule

// File: tb/tb_univ_shreg_n.sv
// tb_univ_shreg_n - self-checking bench for univ_shreg_n (WIDTH=4).
//
// A reference model tracks the register as an array of bits and the burst
// as a number of shifts still owed; every falling edge the DUT outputs are
// compared against it. Directed sequences also check hand-computed values.
// Expected burst behaviour follows UNIV_SHREG_BURST_EN as the DUT does.

module tb_univ_shreg_n;

    localparam int W = 4;

    logic         cp = 1'b0;
    logic         mr;
    logic [2:0]   s;
    logic         dsr;
    logic         dsl;
    logic [0:W-1] d;
    logic         start;
    logic [0:W-1] q;
    logic         qsr;
    logic         qsl;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    univ_shreg_n #(.WIDTH(W)) dut (
        .CP    (cp),
        .MR    (mr),
        .S     (s),
        .DSR   (dsr),
        .DSL   (dsl),
        .D     (d),
        .START (start),
        .Q     (q),
        .QSR   (qsr),
        .QSL   (qsl),
        .BUSY  (busy),
        .DONE  (done)
    );

    always #5 cp = ~cp;

    // ---------------- reference model ----------------
    logic [0:W-1] m_q;
    logic         m_busy;
    logic         m_done;
    logic [2:0]   m_mode;
    int           m_left;
    bit           m_valid = 1'b0;

    // Build each mode from a plain rotation and then patch the entry bit.
    function automatic logic [0:W-1] model_next(
        input logic [2:0]   mode,
        input logic [0:W-1] cur,
        input logic         in_r,
        input logic         in_l,
        input logic [0:W-1] par
    );
        logic [0:W-1] rr;
        logic [0:W-1] rl;
        logic [0:W-1] n;
        for (int i = 0; i < W; i++) begin
            rr[i] = cur[(i + W - 1) % W];
            rl[i] = cur[(i + 1) % W];
        end
        n = cur;
        case (mode)
            3'd0: n = cur;
            3'd1: begin n = rr; n[0] = in_r; end
            3'd2: begin n = rl; n[W-1] = in_l; end
            3'd3: n = par;
            3'd4: n = rr;
            3'd5: n = rl;
            3'd6: begin n = rr; n[0] = cur[0]; end
            default: n = '0;
        endcase
        return n;
    endfunction

    function automatic bit burstable(input logic [2:0] mode);
        return mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    endfunction

    always @(posedge cp) begin
        if (mr === 1'b0) begin
            m_q     = '0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_left  = 0;
            m_mode  = 3'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
`ifdef UNIV_SHREG_BURST_EN
            if (m_left > 0) begin
                m_q    = model_next(m_mode, m_q, dsr, dsl, d);
                m_left = m_left - 1;
                m_busy = (m_left > 0);
                m_done = (m_left == 0);
            end else begin
                m_q    = model_next(s, m_q, dsr, dsl, d);
                m_done = 1'b0;
                m_busy = 1'b0;
                if (start && burstable(s)) begin
                    m_mode = s;
                    m_left = W - 1;
                    m_busy = (m_left > 0);
                    m_done = (m_left == 0);
                end
            end
`else
            m_q    = model_next(s, m_q, dsr, dsl, d);
            m_busy = 1'b0;
            m_done = 1'b0;
`endif
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Model-versus-DUT check every cycle once the model has seen a reset.
    always @(negedge cp) begin
        if (m_valid) begin
            compare("model_q", 32'(q), 32'(m_q));
            compare("model_qsr", 32'(qsr), 32'(m_q[W-1]));
            compare("model_qsl", 32'(qsl), 32'(m_q[0]));
            compare("model_busy", 32'(busy), 32'(m_busy));
            compare("model_done", 32'(done), 32'(m_done));
        end
    end

    // Drive one set of inputs for one rising edge, return just after it.
    task automatic apply_stimulus(
        input logic         mr_v,
        input logic [2:0]   s_v,
        input logic         dsr_v,
        input logic         dsl_v,
        input logic [0:W-1] d_v,
        input logic         start_v
    );
        @(negedge cp);
        mr    = mr_v;
        s     = s_v;
        dsr   = dsr_v;
        dsl   = dsl_v;
        d     = d_v;
        start = start_v;
        @(posedge cp);
        #1;
    endtask

    task automatic check_output(
        input string        name,
        input logic [0:W-1] exp_q,
        input logic         exp_busy,
        input logic         exp_done
    );
        compare({name, "_q"}, 32'(q), 32'(exp_q));
        compare({name, "_busy"}, 32'(busy), 32'(exp_busy));
        compare({name, "_done"}, 32'(done), 32'(exp_done));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        mr    = 1'b0;
        s     = 3'b011;
        dsr   = 1'b0;
        dsl   = 1'b0;
        d     = 4'b1111;
        start = 1'b0;

        // reset beats load, then load on release
        apply_stimulus(1'b0, 3'b011, 1'b0, 1'b0, 4'b1111, 1'b0);
        check_output("reset", 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b1111, 1'b0);
        check_output("reset_release", 4'b1111, 1'b0, 1'b0);

        // load and hold
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b1010, 1'b0);
        check_output("load", 4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 3'b000, 1'b1, 1'b1, 4'b0101, 1'b0);
            check_output("hold", 4'b1010, 1'b0, 1'b0);
        end

        // shift right with DSR=1
        apply_stimulus(1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("shr1", 4'b1101, 1'b0, 1'b0);
        compare("shr1_qsl", 32'(qsl), 32'(1'b1));
        compare("shr1_qsr", 32'(qsr), 32'(1'b1));
        apply_stimulus(1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("shr2", 4'b1110, 1'b0, 1'b0);
        compare("shr2_qsr", 32'(qsr), 32'(1'b0));

        // shift left with DSL=0
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b1010, 1'b0);
        apply_stimulus(1'b1, 3'b010, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("shl", 4'b0100, 1'b0, 1'b0);

        // rotate right full circle
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b1000, 1'b0);
        apply_stimulus(1'b1, 3'b100, 1'b1, 1'b1, 4'b0000, 1'b0);
        check_output("ror1", 4'b0100, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b100, 1'b1, 1'b1, 4'b0000, 1'b0);
        check_output("ror2", 4'b0010, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b100, 1'b1, 1'b1, 4'b0000, 1'b0);
        check_output("ror3", 4'b0001, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b100, 1'b1, 1'b1, 4'b0000, 1'b0);
        check_output("ror4", 4'b1000, 1'b0, 1'b0);

        // arithmetic shift right keeps the end bit, then clear
        apply_stimulus(1'b1, 3'b110, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("asr", 4'b1100, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b111, 1'b1, 1'b1, 4'b1111, 1'b0);
        check_output("clear", 4'b0000, 1'b0, 1'b0);

        // START with a non-burst mode is ignored
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b0110, 1'b1);
        check_output("start_load", 4'b0110, 1'b0, 1'b0);

        // rotate-left burst from 1011, with a load attempted mid-burst
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b1011, 1'b0);
        apply_stimulus(1'b1, 3'b101, 1'b0, 1'b0, 4'b0000, 1'b1);
`ifdef UNIV_SHREG_BURST_EN
        check_output("burst1", 4'b0111, 1'b1, 1'b0);
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("burst2", 4'b1110, 1'b1, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("burst3", 4'b1101, 1'b1, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("burst4", 4'b1011, 1'b0, 1'b1);
        apply_stimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("burst_after", 4'b1011, 1'b0, 1'b0);
`else
        check_output("burst1", 4'b0111, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("burst2", 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("burst3", 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_output("burst4", 4'b0000, 1'b0, 1'b0);
`endif

        // shift-right burst aborted by reset after two shifts
        apply_stimulus(1'b1, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0);
        apply_stimulus(1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 1'b1);
`ifdef UNIV_SHREG_BURST_EN
        check_output("abort1", 4'b1000, 1'b1, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("abort2", 4'b1100, 1'b1, 1'b0);
`else
        check_output("abort1", 4'b1000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("abort2", 4'b1000, 1'b0, 1'b0);
`endif
        apply_stimulus(1'b0, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("abort_reset", 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("abort_after", 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_output("abort_after2", 4'b0000, 1'b0, 1'b0);

        @(negedge cp);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
